// File: rtl/sc_button_conditioner.sv
// sc_button_conditioner
// Conditions three raw active-low push-buttons (start, left, right) into
// debounced active-low levels plus a one-cycle active-low press pulse each.
// Every button gets its own identical channel: a two-flop synchronizer, a
// debounce counter and a four-state FSM with registered outputs. The
// channels share only the clock and the reset.

module sc_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic SC_BUTTON_CONDITIONER_CLOCK_50,
    input  logic SC_BUTTON_CONDITIONER_RESET_InLow,
    input  logic SC_BUTTON_CONDITIONER_startButton_InLow,
    input  logic SC_BUTTON_CONDITIONER_leftButton_InLow,
    input  logic SC_BUTTON_CONDITIONER_rightButton_InLow,
    output logic SC_BUTTON_CONDITIONER_startButton_OutLow,
    output logic SC_BUTTON_CONDITIONER_leftButton_OutLow,
    output logic SC_BUTTON_CONDITIONER_rightButton_OutLow,
    output logic SC_BUTTON_CONDITIONER_startPress_OutLow,
    output logic SC_BUTTON_CONDITIONER_leftPress_OutLow,
    output logic SC_BUTTON_CONDITIONER_rightPress_OutLow
);

    localparam int NUM_BUTTONS = 3;

    // Last counter value of a debounce window; reaching it with the input
    // still stable completes the window.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,  // released, waiting for a low sample
        ST_PRESS_WAIT   = 2'd1,  // low seen, counting stable low samples
        ST_HELD         = 2'd2,  // press accepted, waiting for a high sample
        ST_RELEASE_WAIT = 2'd3   // high seen, counting stable high samples
    } state_t;

    logic                   w_clk;
    logic                   w_rst_n;
    logic [NUM_BUTTONS-1:0] w_raw_n;
    logic [NUM_BUTTONS-1:0] w_level_n;
    logic [NUM_BUTTONS-1:0] w_press_n;

    assign w_clk   = SC_BUTTON_CONDITIONER_CLOCK_50;
    assign w_rst_n = SC_BUTTON_CONDITIONER_RESET_InLow;

    // Channel order: 0 = start, 1 = left, 2 = right.
    assign w_raw_n = {SC_BUTTON_CONDITIONER_rightButton_InLow,
                      SC_BUTTON_CONDITIONER_leftButton_InLow,
                      SC_BUTTON_CONDITIONER_startButton_InLow};

    assign SC_BUTTON_CONDITIONER_startButton_OutLow = w_level_n[0];
    assign SC_BUTTON_CONDITIONER_leftButton_OutLow  = w_level_n[1];
    assign SC_BUTTON_CONDITIONER_rightButton_OutLow = w_level_n[2];
    assign SC_BUTTON_CONDITIONER_startPress_OutLow  = w_press_n[0];
    assign SC_BUTTON_CONDITIONER_leftPress_OutLow   = w_press_n[1];
    assign SC_BUTTON_CONDITIONER_rightPress_OutLow  = w_press_n[2];

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_channel

        logic                 r_sync1;
        logic                 r_sync2;
        state_t               r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_level_n;
        logic                 r_press_n;

        state_t               w_state_next;
        logic [CNT_WIDTH-1:0] w_cnt_next;
        logic                 w_level_next_n;
        logic                 w_press_next_n;

        // Two-flop synchronizer; resets to the released level so a reset never
        // looks like a press.
        always_ff @(posedge w_clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments make r_sync2 take the old
                // r_sync1, giving the intended two-edge delay; blocking here
                // would collapse the chain into a single flop.
                r_sync1 <= w_raw_n[g];
                r_sync2 <= r_sync1;
            end
        end

        // State register, debounce counter and registered outputs.
        always_ff @(posedge w_clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_level_n <= 1'b1;
                r_press_n <= 1'b1;
            end else begin
                r_state   <= w_state_next;
                r_cnt     <= w_cnt_next;
                r_level_n <= w_level_next_n;
                r_press_n <= w_press_next_n;
            end
        end

        // Next-state and next-counter decode from the synchronized input.
        always_comb begin
            // NOTE: defaulting every output of this block first means no path
            // leaves a value unassigned, so no latch is inferred.
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        w_state_next = ST_PRESS_WAIT;
                        w_cnt_next   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (r_sync2) begin
                        // Bounce: the low did not last a full window.
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_HELD: begin
                    if (r_sync2) begin
                        w_state_next = ST_RELEASE_WAIT;
                        w_cnt_next   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!r_sync2) begin
                        // Release bounce: stay pressed, no new pulse.
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end

        // Output decode from the upcoming state so the registered outputs
        // change on the same edge as the state transition.
        always_comb begin
            w_level_next_n = !((w_state_next == ST_HELD) ||
                               (w_state_next == ST_RELEASE_WAIT));
            w_press_next_n = !((r_state == ST_PRESS_WAIT) &&
                               (w_state_next == ST_HELD));
        end

        assign w_level_n[g] = r_level_n;
        assign w_press_n[g] = r_press_n;

    end : g_channel

endmodule

// File: tb/tb_sc_button_conditioner.sv
// Testbench for sc_button_conditioner with DEBOUNCE_CYCLES = 4.
// A run-length reference model predicts every output after every clock edge:
// the synchronized input is the raw value from two edges earlier, and the
// accepted level flips once DEBOUNCE_CYCLES+1 consecutive synchronized
// samples disagree with it.

module tb_sc_button_conditioner;

    localparam int D  = 4;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] raw_n;
    logic [2:0] lvl_n;
    logic [2:0] prs_n;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state per button (0 = start, 1 = left, 2 = right).
    int   m_run [3];
    logic m_lvl [3];
    logic m_prs [3];
    logic m_d1  [3];
    logic m_d2  [3];
    string names [3] = '{"start", "left", "right"};

    always #5 clk = ~clk;

    sc_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_WIDTH       (CW)
    ) dut (
        .SC_BUTTON_CONDITIONER_CLOCK_50          (clk),
        .SC_BUTTON_CONDITIONER_RESET_InLow       (rst_n),
        .SC_BUTTON_CONDITIONER_startButton_InLow (raw_n[0]),
        .SC_BUTTON_CONDITIONER_leftButton_InLow  (raw_n[1]),
        .SC_BUTTON_CONDITIONER_rightButton_InLow (raw_n[2]),
        .SC_BUTTON_CONDITIONER_startButton_OutLow(lvl_n[0]),
        .SC_BUTTON_CONDITIONER_leftButton_OutLow (lvl_n[1]),
        .SC_BUTTON_CONDITIONER_rightButton_OutLow(lvl_n[2]),
        .SC_BUTTON_CONDITIONER_startPress_OutLow (prs_n[0]),
        .SC_BUTTON_CONDITIONER_leftPress_OutLow  (prs_n[1]),
        .SC_BUTTON_CONDITIONER_rightPress_OutLow (prs_n[2])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_run[b] = 0;
            m_lvl[b] = 1'b1;
            m_prs[b] = 1'b1;
            m_d1[b]  = 1'b1;
            m_d2[b]  = 1'b1;
        end
    endtask

    task automatic check_all(input string where);
        for (int b = 0; b < 3; b++) begin
            check($sformatf("%s_%s_level", where, names[b]), lvl_n[b], m_lvl[b]);
            check($sformatf("%s_%s_press", where, names[b]), prs_n[b], m_prs[b]);
        end
    endtask

    // One rising edge: advance the model, then compare all outputs.
    task automatic tick();
        logic obs;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int b = 0; b < 3; b++) begin
                obs      = m_d2[b];
                m_d2[b]  = m_d1[b];
                m_d1[b]  = raw_n[b];
                m_prs[b] = 1'b1;
                m_run[b] = (obs != m_lvl[b]) ? m_run[b] + 1 : 0;
                if (m_run[b] == D + 1) begin
                    m_lvl[b] = obs;
                    m_run[b] = 0;
                    if (!obs) m_prs[b] = 1'b0;
                end
            end
        end
        #1;
        check_all("edge");
    endtask

    task automatic step(input logic [2:0] v);
        @(negedge clk);
        raw_n = v;
        tick();
    endtask

    initial begin
        int pulses;
        int hold [3];
        logic [2:0] rv;

        // Reset state
        rst_n = 1'b0;
        raw_n = 3'b111;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        tick();
        repeat (5) step(3'b111);

        // Clean press on left: accepted on edge D+3, pulse lasts one edge
        for (int e = 1; e <= 9; e++) begin
            step(3'b101);
            check("clean_left_level", lvl_n[1], (e >= D + 3) ? 1'b0 : 1'b1);
            check("clean_left_press", prs_n[1], (e == D + 3) ? 1'b0 : 1'b1);
        end
        // Clean release on left: same latency, no pulse
        for (int e = 1; e <= 9; e++) begin
            step(3'b111);
            check("release_left_level", lvl_n[1], (e >= D + 3) ? 1'b1 : 1'b0);
            check("release_left_press", prs_n[1], 1'b1);
        end

        // Bounce on start: 3 low edges, 1 high edge, five times
        repeat (5) begin
            repeat (3) begin
                step(3'b110);
                check("bounce_start_level", lvl_n[0], 1'b1);
                check("bounce_start_press", prs_n[0], 1'b1);
            end
            step(3'b111);
        end
        repeat (8) step(3'b111);

        // Release with bounce on right
        repeat (10) step(3'b011);
        check("right_held", lvl_n[2], 1'b0);
        step(3'b111);
        step(3'b111);
        step(3'b011);
        for (int e = 1; e <= 9; e++) begin
            step(3'b111);
            check("relbounce_right_level", lvl_n[2], (e >= D + 3) ? 1'b1 : 1'b0);
            check("relbounce_right_press", prs_n[2], 1'b1);
        end

        // Simultaneous start + right
        for (int e = 1; e <= 9; e++) begin
            step(3'b010);
            check("simul_start_press", prs_n[0], (e == D + 3) ? 1'b0 : 1'b1);
            check("simul_right_press", prs_n[2], (e == D + 3) ? 1'b0 : 1'b1);
            check("simul_left_level", lvl_n[1], 1'b1);
        end
        repeat (9) step(3'b111);

        // Reset while left is held, then re-acceptance after reset
        repeat (10) step(3'b101);
        check("pre_reset_left_level", lvl_n[1], 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        tick();
        tick();
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            if (e > 1) @(negedge clk);
            tick();
            if (!prs_n[1]) pulses++;
            check("post_reset_left_press", prs_n[1], (e == D + 3) ? 1'b0 : 1'b1);
        end
        check("post_reset_left_pulses", (pulses == 1), 1'b1);
        repeat (9) step(3'b111);

        // Long hold on right: exactly one pulse
        pulses = 0;
        repeat (1000) begin
            step(3'b011);
            if (!prs_n[2]) pulses++;
        end
        check("long_hold_right_pulses", (pulses == 1), 1'b1);
        check("long_hold_right_level", lvl_n[2], 1'b0);
        repeat (9) step(3'b111);

        // Randomized bouncing on all three buttons
        rv = 3'b111;
        for (int b = 0; b < 3; b++) hold[b] = 0;
        repeat (2000) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    rv[b]   = 1'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 10));
                end
                hold[b]--;
            end
            step(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
